// File: rtl/fpu_req_scheduler.sv
// Round-robin scheduler sharing one FPU core among NREQ requesters; each
// accepted request yields exactly one tagged response (result, flags, error).
module fpu_req_scheduler #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_a,
  input  logic [32*NREQ-1:0]  req_b,
  input  logic [3*NREQ-1:0]   req_op,
  input  logic [3*NREQ-1:0]   req_rnd,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_data,
  output logic [7:0]          rsp_flags,
  output logic [1:0]          rsp_err,
  output logic [31:0]         fpu_in1,
  output logic [31:0]         fpu_in2,
  output logic [2:0]          fpu_opcode,
  output logic [2:0]          fpu_round,
  output logic                fpu_rst,
  output logic                fpu_act,
  input  logic [31:0]         fpu_out,
  input  logic [7:0]          fpu_flags,
  input  logic                fpu_done,
  output logic                busy
);

  localparam logic [2:0]     OP_ADD      = 3'd0;
  localparam logic [2:0]     OP_CMP      = 3'd4;
  localparam logic [1:0]     ERR_OK      = 2'd0;
  localparam logic [1:0]     ERR_ILLEGAL = 2'd1;
  localparam logic [1:0]     ERR_TIMEOUT = 2'd2;
  localparam logic [5:0]     CNT_LAST    = 6'(TIMEOUT - 1);
  localparam logic [IDW-1:0] PTR_RESET   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q;
  logic [5:0]     cnt_q;
  logic [31:0]    in1_q, in2_q;
  logic [2:0]     op_q, rnd_q;
  logic           fpu_rst_q, fpu_act_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_data_q;
  logic [7:0]     rsp_flags_q;
  logic [1:0]     rsp_err_q;

  logic [IDW-1:0] win_idx_d;
  logic           win_valid_d;
  logic [31:0]    win_a_d, win_b_d;
  logic [2:0]     win_op_d, win_rnd_d;
  logic           win_legal_d;
  int             cand;

  // Search starts just after the last winner and wraps, so the previous
  // winner has the lowest priority in the next round.
  always_comb begin
    win_idx_d   = '0;
    win_valid_d = 1'b0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + 1 + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_valid_d && req_valid[cand]) begin
        win_valid_d = 1'b1;
        win_idx_d   = IDW'(cand);
      end
    end
  end

  assign win_a_d     = req_a[32*int'(win_idx_d) +: 32];
  assign win_b_d     = req_b[32*int'(win_idx_d) +: 32];
  assign win_op_d    = req_op[3*int'(win_idx_d) +: 3];
  assign win_rnd_d   = req_rnd[3*int'(win_idx_d) +: 3];
  assign win_legal_d = (win_op_d == OP_ADD) || (win_op_d == OP_CMP);

  always_comb begin
    req_ready = '0;
    if (wb_rst_ni && state_q == IDLE && win_valid_d) req_ready[win_idx_d] = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_RESET;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= '0;
      rnd_q       <= '0;
      fpu_rst_q   <= 1'b0;
      fpu_act_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid_d) begin
            ptr_q    <= win_idx_d;
            rsp_id_q <= win_idx_d;
            if (win_legal_d) begin
              in1_q     <= win_a_d;
              in2_q     <= win_b_d;
              op_q      <= win_op_d;
              rnd_q     <= win_rnd_d;
              fpu_rst_q <= 1'b1;
              state_q   <= CLEAR;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_flags_q <= '0;
              rsp_err_q   <= ERR_ILLEGAL;
              state_q     <= RESP;
            end
          end
        end
        CLEAR: begin
          fpu_rst_q <= 1'b0;
          fpu_act_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= RUN;
        end
        RUN: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (fpu_done || cnt_q == CNT_LAST) begin
            fpu_act_q   <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= '0;
            rnd_q       <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
            if (fpu_done) begin
              rsp_data_q  <= (op_q == OP_CMP) ? 32'd0 : fpu_out;
              rsp_flags_q <= fpu_flags;
              rsp_err_q   <= ERR_OK;
            end else begin
              rsp_data_q  <= '0;
              rsp_flags_q <= '0;
              rsp_err_q   <= ERR_TIMEOUT;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fpu_in1    = in1_q;
  assign fpu_in2    = in2_q;
  assign fpu_opcode = op_q;
  assign fpu_round  = rnd_q;
  assign fpu_rst    = fpu_rst_q;
  assign fpu_act    = fpu_act_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Directed self-checking bench for fpu_req_scheduler; a small behavioural
// FPU core answers with bench-chosen results after a bench-chosen latency.
module tb_fpu_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [5:0]  req_op, req_rnd;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic [1:0]  rsp_err;
  logic [31:0] fpu_in1, fpu_in2, fpu_out;
  logic [2:0]  fpu_opcode, fpu_round;
  logic        fpu_rst, fpu_act, fpu_done, busy;
  logic [7:0]  fpu_flags;

  int          n_cmp = 0;
  int          n_fail = 0;

  int          core_lat = 0;
  logic        core_hang = 1'b0;
  logic [31:0] core_out = '0;
  logic [7:0]  core_flags = '0;
  int          run_cnt = 0;

  int          both_cnt = 0;
  int          act_cycles = 0;
  logic        rst_seen = 1'b0;
  logic        act_seen = 1'b0;

  fpu_req_scheduler #(.NREQ(2), .IDW(1), .TIMEOUT(64)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rnd(req_rnd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_opcode(fpu_opcode),
    .fpu_round(fpu_round), .fpu_rst(fpu_rst), .fpu_act(fpu_act),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags), .fpu_done(fpu_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign fpu_out   = core_out;
  assign fpu_flags = core_flags;

  // Behavioural core: done rises core_lat cycles into activation.
  always @(posedge clk) begin
    #2;
    if (fpu_act) begin
      fpu_done = !core_hang && (run_cnt == core_lat);
      run_cnt++;
    end else begin
      fpu_done = 1'b0;
      run_cnt  = 0;
    end
  end

  always @(negedge clk) begin
    if (&req_ready) both_cnt++;
    if (fpu_rst) rst_seen = 1'b1;
    if (fpu_act) begin
      act_seen = 1'b1;
      act_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [1:0] rdy, output int n);
    rdy = '0;
    n   = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00) begin
        rdy = req_ready;
        break;
      end
    end
  endtask

  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, output logic [1:0] rdy);
    int n;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_op[3*idx +: 3]  = op;
    req_rnd[3*idx +: 3] = 3'd1;
    req_valid[idx]      = 1'b1;
    wait_grant(rdy, n);
    tick();
    req_valid = '0;
  endtask

  // Counts falling edges after the accept edge until rsp_valid appears.
  task automatic wait_rsp(output int n, output logic [31:0] in1_run, output logic act_run);
    n       = 0;
    in1_run = '0;
    act_run = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        in1_run = fpu_in1;
        act_run = fpu_act;
      end
      if (rsp_valid) break;
    end
  endtask

  task automatic consume();
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_rnd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready got %b expected 00", req_ready); end
    n_cmp++;
    if ({rsp_valid, busy, fpu_rst, fpu_act} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_ctrl got %b expected 0000", {rsp_valid, busy, fpu_rst, fpu_act});
    end
    n_cmp++;
    if ({rsp_id, rsp_data, rsp_flags, rsp_err, fpu_in1, fpu_in2, fpu_opcode, fpu_round} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_data got nonzero data/operand outputs, expected all 0");
    end
    tick();
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  rdy, exp_rdy;
    logic [31:0] in1_run;
    logic        act_run;
    int          n, cnt0, cnt1;
    core_lat = 0; core_hang = 1'b0; core_out = 32'h0000_1234; core_flags = '0;
    both_cnt = 0;
    req_a = {32'h2222_2222, 32'h1111_1111};
    req_b = {32'h4444_4444, 32'h3333_3333};
    req_op = '0;
    cnt0 = 3; cnt1 = 3;
    req_valid = 2'b11;
    for (int g = 0; g < 6; g++) begin
      exp_rdy = (g % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(rdy, n);
      n_cmp++;
      if (rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL rr_grant%0d got %b expected %b", g, rdy, exp_rdy); end
      if (rdy == 2'b00) break;
      tick();
      if (rdy[0]) cnt0--;
      if (rdy[1]) cnt1--;
      req_valid = {cnt1 != 0, cnt0 != 0};
      wait_rsp(n, in1_run, act_run);
      n_cmp++;
      if (rsp_id !== exp_rdy[1]) begin n_fail++; $display("[TB] FAIL rr_id%0d got %0d expected %0d", g, rsp_id, exp_rdy[1]); end
      n_cmp++;
      if (in1_run !== (exp_rdy[1] ? 32'h2222_2222 : 32'h1111_1111)) begin
        n_fail++; $display("[TB] FAIL rr_operand%0d got %h", g, in1_run);
      end
      consume();
    end
    req_valid = 2'b00;
    n_cmp++;
    if (both_cnt !== 0) begin n_fail++; $display("[TB] FAIL rr_both_ready got %0d cycles expected 0", both_cnt); end
  endtask

  task automatic test_single_add();
    logic [1:0]  rdy;
    logic [31:0] in1_run;
    logic        act_run;
    int          n;
    core_lat = 0; core_hang = 1'b0; core_out = 32'h4040_0000; core_flags = 8'h00;
    issue(0, 32'h3F80_0000, 32'h4000_0000, 3'd0, rdy);
    n_cmp++;
    if (rdy !== 2'b01) begin n_fail++; $display("[TB] FAIL add_grant got %b expected 01", rdy); end
    wait_rsp(n, in1_run, act_run);
    n_cmp++;
    if (n !== 3) begin n_fail++; $display("[TB] FAIL add_latency got %0d expected 3", n); end
    n_cmp++;
    if ({act_run, in1_run} !== {1'b1, 32'h3F80_0000}) begin
      n_fail++; $display("[TB] FAIL add_run got act=%b in1=%h expected act=1 in1=3f800000", act_run, in1_run);
    end
    n_cmp++;
    if ({rsp_id, rsp_data, rsp_err} !== {1'b0, 32'h4040_0000, 2'd0}) begin
      n_fail++; $display("[TB] FAIL add_rsp got id=%0d data=%h err=%0d expected 0/40400000/0", rsp_id, rsp_data, rsp_err);
    end
    consume();
  endtask

  task automatic test_illegal();
    logic [1:0]  rdy;
    logic [31:0] in1_run;
    logic        act_run;
    int          n;
    core_out = 32'hDEAD_BEEF; core_flags = 8'hFF;
    rst_seen = 1'b0; act_seen = 1'b0;
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 3'd2, rdy);
    n_cmp++;
    if (rdy !== 2'b10) begin n_fail++; $display("[TB] FAIL ill_grant got %b expected 10", rdy); end
    wait_rsp(n, in1_run, act_run);
    n_cmp++;
    if (n !== 1) begin n_fail++; $display("[TB] FAIL ill_latency got %0d expected 1", n); end
    n_cmp++;
    if ({rsp_id, rsp_data, rsp_flags, rsp_err} !== {1'b1, 32'd0, 8'd0, 2'd1}) begin
      n_fail++; $display("[TB] FAIL ill_rsp got id=%0d data=%h flags=%h err=%0d expected 1/0/0/1", rsp_id, rsp_data, rsp_flags, rsp_err);
    end
    consume();
    repeat (2) tick();
    n_cmp++;
    if ({rst_seen, act_seen} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL ill_core_touched got rst=%b act=%b expected 0/0", rst_seen, act_seen);
    end
  endtask

  task automatic test_compare();
    logic [1:0]  rdy;
    logic [31:0] in1_run;
    logic        act_run;
    int          n;
    core_lat = 0; core_hang = 1'b0; core_out = 32'h3F80_0000; core_flags = 8'h04;
    issue(0, 32'h4000_0000, 32'h3F80_0000, 3'd4, rdy);
    wait_rsp(n, in1_run, act_run);
    n_cmp++;
    if (n !== 3) begin n_fail++; $display("[TB] FAIL cmp_latency got %0d expected 3", n); end
    n_cmp++;
    if (rsp_data !== 32'd0) begin n_fail++; $display("[TB] FAIL cmp_data got %h expected 0", rsp_data); end
    n_cmp++;
    if ({rsp_flags[4], rsp_flags[3], rsp_flags[2], rsp_err} !== {3'b001, 2'd0}) begin
      n_fail++; $display("[TB] FAIL cmp_flags got less=%b eq=%b great=%b err=%0d expected 0/0/1/0",
                         rsp_flags[4], rsp_flags[3], rsp_flags[2], rsp_err);
    end
    consume();
  endtask

  task automatic test_timeout();
    logic [1:0]  rdy;
    logic [31:0] in1_run;
    logic        act_run;
    int          n;
    core_hang = 1'b1; core_out = 32'hDEAD_BEEF; core_flags = 8'hFF;
    issue(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, rdy);
    act_cycles = 0;
    wait_rsp(n, in1_run, act_run);
    n_cmp++;
    if (n !== 66) begin n_fail++; $display("[TB] FAIL to_latency got %0d expected 66", n); end
    n_cmp++;
    if (act_cycles !== 64) begin n_fail++; $display("[TB] FAIL to_run_len got %0d expected 64", act_cycles); end
    n_cmp++;
    if ({rsp_data, rsp_flags, rsp_err} !== {32'd0, 8'd0, 2'd2}) begin
      n_fail++; $display("[TB] FAIL to_rsp got data=%h flags=%h err=%0d expected 0/0/2", rsp_data, rsp_flags, rsp_err);
    end
    core_hang = 1'b0;
    consume();
  endtask

  task automatic test_reset_mid_run_and_stall();
    logic [1:0]  rdy;
    logic [31:0] in1_run;
    logic        act_run;
    logic [42:0] held;
    int          n;
    core_hang = 1'b1; core_out = 32'h4040_0000; core_flags = 8'h80;
    issue(1, 32'h3F80_0000, 32'h4000_0000, 3'd0, rdy);
    repeat (4) tick();
    n_cmp++;
    if (fpu_act !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_run got act=%b expected 1", fpu_act); end
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = {32'h5555_5555, 32'h3F80_0000};
    req_op = 6'd0;
    #1;
    n_cmp++;
    if ({fpu_act, fpu_rst, busy, rsp_valid, req_ready, fpu_in1} !== '0) begin
      n_fail++; $display("[TB] FAIL rst_async got act=%b busy=%b rsp_valid=%b ready=%b in1=%h expected all 0",
                         fpu_act, busy, rsp_valid, req_ready, fpu_in1);
    end
    tick(); tick();
    core_hang = 1'b0; core_lat = 0;
    rst_n = 1'b1;
    wait_grant(rdy, n);
    n_cmp++;
    if (rdy !== 2'b01) begin n_fail++; $display("[TB] FAIL rst_first_winner got %b expected 01", rdy); end
    tick();
    req_valid = 2'b00;
    wait_rsp(n, in1_run, act_run);
    n_cmp++;
    if ({n[7:0], rsp_id, rsp_data, rsp_flags, rsp_err} !== {8'd3, 1'b0, 32'h4040_0000, 8'h80, 2'd0}) begin
      n_fail++; $display("[TB] FAIL rst_next_rsp got n=%0d id=%0d data=%h flags=%h err=%0d expected 3/0/40400000/80/0",
                         n, rsp_id, rsp_data, rsp_flags, rsp_err);
    end
    held = {rsp_id, rsp_data, rsp_flags, rsp_err};
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err} !== {1'b1, held}) begin
        n_fail++; $display("[TB] FAIL stall%0d got valid=%b data=%h expected held response", s, rsp_valid, rsp_data);
      end
    end
    consume();
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL stall_release got valid=%b busy=%b expected 0/0", rsp_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_add();
    test_illegal();
    test_compare();
    test_timeout();
    test_reset_mid_run_and_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
